greater_result_checker: RTL and testbench

Receive-side checker for the ALU "greater" result word. It accepts the 32-bit sign-extended result and its balance (parity) bit over a valid/ready handshake. It recovers the 5-bit operand value and verifies both the balance bit and the sign extension. It reports per-word status and keeps saturating statistics counters for the test/debug path downstream of the ALU.

---
 rtl/greater_result_checker.sv | 124 ++++++++++++
 tb/tb_greater_result_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/greater_result_checker.sv
// Receive-side checker for the ALU "greater" result word: recovers the 5-bit operand,
// verifies balance bit and sign extension, and keeps saturating word/error counters.
module greater_result_checker #(
    parameter int unsigned CNT_W     = 8,
    parameter bit          CHECK_EXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      conclusion,
    input  logic             balancebit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4:0]       value,
    output logic             parity_ok,
    output logic             ext_ok,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned VAL_W  = 5;
    localparam int unsigned EXT_W  = DATA_W - VAL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] cap_word, cap_word_d;
    logic              cap_bal, cap_bal_d;
    logic [VAL_W-1:0]  value_d;
    logic              parity_ok_d, ext_ok_d;
    logic              in_ready_d, out_valid_d;
    logic [CNT_W-1:0]  word_cnt_d, err_cnt_d;
    logic              handshake;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_word  <= '0;
            cap_bal   <= 1'b0;
            value     <= '0;
            parity_ok <= 1'b0;
            ext_ok    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            word_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            cap_word  <= cap_word_d;
            cap_bal   <= cap_bal_d;
            value     <= value_d;
            parity_ok <= parity_ok_d;
            ext_ok    <= ext_ok_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            word_cnt  <= word_cnt_d;
            err_cnt   <= err_cnt_d;
        end
    end

    // Next-state, checks and counter updates
    always_comb begin
        state_d     = state;
        cap_word_d  = cap_word;
        cap_bal_d   = cap_bal;
        value_d     = value;
        parity_ok_d = parity_ok;
        ext_ok_d    = ext_ok;
        word_cnt_d  = word_cnt;
        err_cnt_d   = err_cnt;
        handshake   = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    cap_word_d = conclusion;
                    cap_bal_d  = balancebit;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                value_d     = cap_word[VAL_W-1:0];
                // Even popcount (including zero) means xor-reduction is 0
                parity_ok_d = (cap_bal == ~(^cap_word[VAL_W-1:0]));
                ext_ok_d    = CHECK_EXT ? (cap_word[DATA_W-1:VAL_W] == {EXT_W{cap_word[VAL_W-1]}})
                                        : 1'b1;
                state_d     = REPORT;
            end
            REPORT: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == REPORT);

        // Clear wins over a simultaneous handshake increment
        if (clr_cnt) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (handshake) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt_d = word_cnt + CNT_W'(1);
            end
            if (!(parity_ok && ext_ok) && (err_cnt != CNT_MAX)) begin
                err_cnt_d = err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_greater_result_checker.sv
// Randomized and directed bench for greater_result_checker; three instances share one
// stimulus stream: default, sign-extension check disabled, and 2-bit counters.
module tb_greater_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] conclusion;
    logic        balancebit, in_valid, out_ready, clr_cnt;

    logic       in_ready_a, in_ready_b, in_ready_c;
    logic [4:0] value_a, value_b, value_c;
    logic       parity_ok_a, parity_ok_b, parity_ok_c;
    logic       ext_ok_a, ext_ok_b, ext_ok_c;
    logic       out_valid_a, out_valid_b, out_valid_c;
    logic [7:0] word_cnt_a, err_cnt_a, word_cnt_b, err_cnt_b;
    logic [1:0] word_cnt_c, err_cnt_c;

    int errors = 0;
    int checks = 0;
    int wa = 0, ea = 0, wb = 0, eb = 0, wc = 0, ec = 0;

    always #5 clk = ~clk;

    greater_result_checker #(.CNT_W(8), .CHECK_EXT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .conclusion(conclusion), .balancebit(balancebit),
        .in_valid(in_valid), .in_ready(in_ready_a), .value(value_a), .parity_ok(parity_ok_a),
        .ext_ok(ext_ok_a), .out_valid(out_valid_a), .out_ready(out_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt_a), .err_cnt(err_cnt_a));

    greater_result_checker #(.CNT_W(8), .CHECK_EXT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .conclusion(conclusion), .balancebit(balancebit),
        .in_valid(in_valid), .in_ready(in_ready_b), .value(value_b), .parity_ok(parity_ok_b),
        .ext_ok(ext_ok_b), .out_valid(out_valid_b), .out_ready(out_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt_b), .err_cnt(err_cnt_b));

    greater_result_checker #(.CNT_W(2), .CHECK_EXT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .conclusion(conclusion), .balancebit(balancebit),
        .in_valid(in_valid), .in_ready(in_ready_c), .value(value_c), .parity_ok(parity_ok_c),
        .ext_ok(ext_ok_c), .out_valid(out_valid_c), .out_ready(out_ready), .clr_cnt(clr_cnt),
        .word_cnt(word_cnt_c), .err_cnt(err_cnt_c));

    // Reference rules: balance bit set means an even number of ones in the low five bits;
    // a correctly sign-extended word is a signed 32-bit value in -16..15.
    function automatic logic ref_par(input logic [31:0] w, input logic b);
        return b == (($countones(w[4:0]) % 2) == 0);
    endfunction

    function automatic logic ref_ext(input logic [31:0] w);
        return ($signed(w) >= -16) && ($signed(w) <= 15);
    endfunction

    function automatic logic [26:0] got_out();
        return {out_valid_a, out_valid_b, out_valid_c, in_ready_a, in_ready_b, in_ready_c,
                value_a, value_b, value_c, parity_ok_a, parity_ok_b, parity_ok_c,
                ext_ok_a, ext_ok_b, ext_ok_c};
    endfunction

    function automatic logic [26:0] exp_out(input logic ov, input logic ir,
                                            input logic [31:0] w, input logic b);
        logic p, e;
        p = ref_par(w, b);
        e = ref_ext(w);
        return {ov, ov, ov, ir, ir, ir, w[4:0], w[4:0], w[4:0], p, p, p, e, 1'b1, e};
    endfunction

    function automatic logic [5:0] got_hs();
        return {out_valid_a, out_valid_b, out_valid_c, in_ready_a, in_ready_b, in_ready_c};
    endfunction

    function automatic logic [35:0] got_cnt();
        return {word_cnt_a, err_cnt_a, word_cnt_b, err_cnt_b, word_cnt_c, err_cnt_c};
    endfunction

    function automatic logic [35:0] exp_cnt();
        return {8'(wa), 8'(ea), 8'(wb), 8'(eb), 2'(wc), 2'(ec)};
    endfunction

    task automatic model_handshake(input logic [31:0] w, input logic b, input bit clr);
        if (clr) begin
            wa = 0; ea = 0; wb = 0; eb = 0; wc = 0; ec = 0;
        end else begin
            wa = (wa < 255) ? wa + 1 : 255;
            wb = (wb < 255) ? wb + 1 : 255;
            wc = (wc < 3) ? wc + 1 : 3;
            if (!(ref_par(w, b) && ref_ext(w))) begin
                ea = (ea < 255) ? ea + 1 : 255;
                ec = (ec < 3) ? ec + 1 : 3;
            end
            if (!ref_par(w, b)) eb = (eb < 255) ? eb + 1 : 255;
        end
    endtask

    // One word through the checker; hold = cycles out_ready stays low in REPORT
    task automatic send_word(input logic [31:0] w, input logic b, input int hold, input bit clr);
        conclusion = w;
        balancebit = b;
        in_valid   = 1'b1;
        out_ready  = (hold == 0);
        clr_cnt    = 1'b0;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        conclusion = $urandom;
        balancebit = 1'($urandom);
        checks++;
        if (got_hs() !== 6'b000_000) begin
            errors++;
            $display("FAIL check_phase w=%h: got %b exp %b", w, got_hs(), 6'b000_000);
        end
        @(posedge clk); #1;
        checks++;
        if (got_out() !== exp_out(1'b1, 1'b0, w, b)) begin
            errors++;
            $display("FAIL report w=%h b=%b: got %h exp %h", w, b, got_out(), exp_out(1'b1, 1'b0, w, b));
        end
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            conclusion = ~w;
            @(posedge clk); #1;
            checks++;
            if (got_out() !== exp_out(1'b1, 1'b0, w, b) || got_cnt() !== exp_cnt()) begin
                errors++;
                $display("FAIL hold w=%h cyc=%0d: got %h/%h exp %h/%h", w, i, got_out(), got_cnt(),
                         exp_out(1'b1, 1'b0, w, b), exp_cnt());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = clr;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        model_handshake(w, b, clr);
        checks++;
        if (got_out() !== exp_out(1'b0, 1'b1, w, b) || got_cnt() !== exp_cnt()) begin
            errors++;
            $display("FAIL handshake w=%h: got %h/%h exp %h/%h", w, got_out(), got_cnt(),
                     exp_out(1'b0, 1'b1, w, b), exp_cnt());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; conclusion = '0; balancebit = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_out() !== {3'b000, 3'b111, 15'd0, 3'b000, 3'b000} || got_cnt() !== 36'd0) begin
            errors++;
            $display("FAIL reset: got %h/%h exp %h/0", got_out(), got_cnt(),
                     {3'b000, 3'b111, 15'd0, 3'b000, 3'b000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_word(32'h0000_0006, 1'b1, 0, 1'b0);
        checks++;
        if ({value_a, parity_ok_a, ext_ok_a, word_cnt_a, err_cnt_a} !== {5'd6, 1'b1, 1'b1, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL basic: got v=%h p=%b e=%b w=%0d e=%0d exp v=06 p=1 e=1 w=1 e=0",
                     value_a, parity_ok_a, ext_ok_a, word_cnt_a, err_cnt_a);
        end
    endtask

    task automatic test_ext_parity();
        send_word(32'hFFFF_FFF3, 1'b0, 0, 1'b0);
        send_word(32'hFFFF_FFF3, 1'b1, 0, 1'b0);
        checks++;
        if ({value_a, parity_ok_a, err_cnt_a} !== {5'h13, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL neg_parity: got v=%h p=%b err=%0d exp v=13 p=0 err=1",
                     value_a, parity_ok_a, err_cnt_a);
        end
        send_word(32'h0000_0013, 1'b0, 0, 1'b0);
        checks++;
        if ({ext_ok_a, parity_ok_a, err_cnt_a, ext_ok_b, err_cnt_b} !== {1'b0, 1'b1, 8'd2, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL bad_ext: got ea=%b pa=%b erra=%0d eb=%b errb=%0d exp 0 1 2 1 1",
                     ext_ok_a, parity_ok_a, err_cnt_a, ext_ok_b, err_cnt_b);
        end
    endtask

    task automatic test_hold();
        send_word(32'h0000_0000, 1'b1, 5, 1'b0);
        checks++;
        if (parity_ok_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_even: got %b exp 1", parity_ok_a);
        end
    endtask

    task automatic test_saturate();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        model_handshake('0, 1'b0, 1'b1);
        checks++;
        if (got_cnt() !== 36'd0) begin
            errors++;
            $display("FAIL clr_alone: got %h exp 0", got_cnt());
        end
        for (int i = 0; i < 5; i++) send_word(32'h0000_0013, 1'b1, 0, 1'b0);
        checks++;
        if ({word_cnt_c, err_cnt_c, word_cnt_a, err_cnt_a} !== {2'd3, 2'd3, 8'd5, 8'd5}) begin
            errors++;
            $display("FAIL saturate: got c=%0d/%0d a=%0d/%0d exp c=3/3 a=5/5",
                     word_cnt_c, err_cnt_c, word_cnt_a, err_cnt_a);
        end
        send_word(32'h0000_0013, 1'b1, 1, 1'b1);
        checks++;
        if (got_cnt() !== 36'd0) begin
            errors++;
            $display("FAIL clr_priority: got %h exp 0", got_cnt());
        end
    endtask

    task automatic test_reset_mid();
        send_word(32'h0000_0005, 1'b1, 0, 1'b0);
        conclusion = 32'hFFFF_FFF8; balancebit = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got_hs() !== 6'b000_111 || got_cnt() !== 36'd0) begin
            errors++;
            $display("FAIL async_reset: got %b/%h exp 000111/0", got_hs(), got_cnt());
        end
        wa = 0; ea = 0; wb = 0; eb = 0; wc = 0; ec = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (got_hs() !== 6'b000_111 || got_cnt() !== 36'd0) begin
            errors++;
            $display("FAIL after_reset: got %b/%h exp 000111/0", got_hs(), got_cnt());
        end
        send_word(32'hFFFF_FFF8, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [4:0]  v;
        for (int n = 0; n < 80; n++) begin
            v = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       w = v[4] ? {27'h7FF_FFFF, v} : {27'h0, v};
                1:       w = $urandom;
                default: begin
                    w = v[4] ? {27'h7FF_FFFF, v} : {27'h0, v};
                    w[$urandom_range(5, 31)] ^= 1'b1;
                end
            endcase
            send_word(w, 1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext_parity();
        test_hold();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
